// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-port memory between instruction fetch and the data path.
// Optional grant counters are built when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter #(
   parameter int unsigned WAIT_CYCLES  = 1,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_done,
   output logic [31:0] d_rdata,
   output logic        stall_if,
   output logic        stall_mem,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic [31:0] perf_if_cnt,
   output logic [31:0] perf_d_cnt
);

   localparam logic [3:0] WAIT_INIT  = 4'(WAIT_CYCLES);
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state;
   logic       owner_d;
   logic       lat_we;
   logic [3:0] wait_cnt;
   logic [3:0] starve_cnt;
   logic       grant_d;
   logic       grant_if;

   // Data wins contention unless fetch has been passed over STARVE_LIMIT times in a row.
   always_comb begin
      grant_d  = 1'b0;
      grant_if = 1'b0;
      if (d_req && (!if_req || (starve_cnt != STARVE_MAX)))
         grant_d = 1'b1;
      else if (if_req)
         grant_if = 1'b1;
   end

   assign stall_if  = if_req & ~if_rvalid;
   assign stall_mem = d_req & ~d_done;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         owner_d    <= 1'b0;
         lat_we     <= 1'b0;
         wait_cnt   <= '0;
         starve_cnt <= '0;
         if_gnt     <= 1'b0;
         if_rvalid  <= 1'b0;
         if_rdata   <= '0;
         d_gnt      <= 1'b0;
         d_done     <= 1'b0;
         d_rdata    <= '0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         if_gnt    <= 1'b0;
         d_gnt     <= 1'b0;
         if_rvalid <= 1'b0;
         d_done    <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_d) begin
                  owner_d   <= 1'b1;
                  lat_we    <= d_we;
                  mem_addr  <= d_addr;
                  mem_wdata <= d_wdata;
                  d_gnt     <= 1'b1;
                  mem_en    <= 1'b1;
                  mem_we    <= d_we;
                  wait_cnt  <= WAIT_INIT;
                  state     <= BUSY;
                  if (if_req) begin
                     if (starve_cnt != STARVE_MAX)
                        starve_cnt <= starve_cnt + 4'd1;
                  end else begin
                     starve_cnt <= '0;
                  end
               end else if (grant_if) begin
                  owner_d    <= 1'b0;
                  lat_we     <= 1'b0;
                  mem_addr   <= if_addr;
                  if_gnt     <= 1'b1;
                  mem_en     <= 1'b1;
                  wait_cnt   <= WAIT_INIT;
                  state      <= BUSY;
                  starve_cnt <= '0;
               end
            end
            BUSY: begin
               // Read data is taken at the end of the last latency cycle.
               if (wait_cnt == 4'd1) begin
                  wait_cnt <= '0;
                  state    <= DONE;
                  if (owner_d) begin
                     d_done <= 1'b1;
                     if (!lat_we)
                        d_rdata <= mem_rdata;
                  end else begin
                     if_rvalid <= 1'b1;
                     if_rdata  <= mem_rdata;
                  end
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef ARB_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_if_cnt <= '0;
         perf_d_cnt  <= '0;
      end else begin
         if (if_gnt)
            perf_if_cnt <= perf_if_cnt + 32'd1;
         if (d_gnt)
            perf_d_cnt <= perf_d_cnt + 32'd1;
      end
   end
`else
   assign perf_if_cnt = '0;
   assign perf_d_cnt  = '0;
`endif

endmodule
